// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and sizing helpers for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  // Bits needed to index n items, never less than one.
  function automatic int ptr_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signals of the port A arbiter
interface mem_port_arbiter_if #(
  parameter int DATA = 8,
  parameter int ADDR = 16,
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      we;
  logic [NREQ-1:0]      lock;
  logic [NREQ*ADDR-1:0] addr;
  logic [NREQ*DATA-1:0] wdata;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rvalid;
  logic [DATA-1:0]      rdata;
  logic [ADDR-1:0]      mem_addr;
  logic [DATA-1:0]      mem_din;
  logic                 mem_we;
  logic [DATA-1:0]      mem_dout;

  // Arbiter side: takes requests and memory read data, drives grants and the port.
  modport slave (
    input  req, we, lock, addr, wdata, mem_dout,
    output gnt, rvalid, rdata, mem_addr, mem_din, mem_we
  );

  // Environment side: the requesters plus the memory itself.
  modport master (
    output req, we, lock, addr, wdata, mem_dout,
    input  gnt, rvalid, rdata, mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/counter.sv
// rtl/counter.sv - loadable up-counter with asynchronous active-low reset
module counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_L,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Load has priority over increment; count clears to zero on reset.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) q <= '0;
    else if (load) q <= load_val;
    else if (inc) q <= q + W'(1);
  end

endmodule

// File: rtl/register.sv
// rtl/register.sv - enabled register with asynchronous active-low reset
module register #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_L,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d when enabled; reset value applied asynchronously.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating priority encoder, search starts at ptr and wraps modulo N
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  int            j;
  logic [PW-1:0] jj;

  // First requester found walking ptr, ptr+1, ... wins; idx falls back to ptr when idle.
  always_comb begin
    gnt = '0;
    idx = ptr;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = PW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter with bounded lock bursts for mem port A
module mem_port_arbiter #(
  parameter int DATA     = 8,
  parameter int ADDR     = 16,
  parameter int NREQ     = 3,
  parameter int MAXBURST = 4
) (
  input  logic clk,
  input  logic rst_L,
  mem_port_arbiter_if.slave bus
);
  import mem_arb_pkg::*;

  localparam int PW = ptr_width(NREQ);
  localparam int CW = ptr_width(MAXBURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'(ARB_IDLE);
  localparam logic [0:0] ST_BURST = 1'(ARB_BURST);

  logic [0:0]      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q;
  logic            cnt_load, cnt_inc;
  logic [NREQ-1:0] rv_q, rv_d;

  logic [PW-1:0]   pick_ptr, pick_idx, win_idx;
  logic [NREQ-1:0] pick_gnt, gnt_raw, gnt_o;
  logic            pick_any, owner_hold, grant_any, we_o;

  function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] v);
    return (int'(v) == NREQ - 1) ? '0 : v + PW'(1);
  endfunction

  // While bursting, anyone else is searched starting just after the owner.
  assign pick_ptr   = (state_q == ST_BURST) ? inc_mod(owner_q) : ptr_q;
  assign owner_hold = (state_q == ST_BURST) && bus.req[owner_q];

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req (bus.req),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign win_idx   = owner_hold ? owner_q : pick_idx;
  assign grant_any = owner_hold | pick_any;
  assign gnt_raw   = owner_hold ? (NREQ'(1) << owner_q) : pick_gnt;

  // Grant and write enable are forced low for as long as reset is held.
  assign gnt_o = rst_L ? gnt_raw : '0;
  assign we_o  = rst_L & grant_any & bus.we[win_idx];

  assign bus.gnt      = gnt_o;
  assign bus.mem_we   = we_o;
  assign bus.mem_addr = bus.addr[int'(win_idx) * ADDR +: ADDR];
  assign bus.mem_din  = bus.wdata[int'(win_idx) * DATA +: DATA];
  assign bus.rdata    = bus.mem_dout;
  assign bus.rvalid   = rv_q;

  // Only read grants produce a data strobe one cycle later.
  assign rv_d = we_o ? '0 : gnt_o;

  // Next-state: hold the burst owner, otherwise round-robin and possibly start a burst.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    if (owner_hold) begin
      cnt_inc = 1'b1;
      if ((cnt_q + CW'(1) >= CW'(MAXBURST)) || !bus.lock[owner_q]) begin
        state_d = ST_IDLE;
        ptr_d   = inc_mod(owner_q);
      end
    end else if (pick_any) begin
      state_d = ST_IDLE;
      ptr_d   = inc_mod(pick_idx);
      if (bus.lock[pick_idx] && (MAXBURST > 1)) begin
        state_d  = ST_BURST;
        owner_d  = pick_idx;
        cnt_load = 1'b1;
        ptr_d    = ptr_q;
      end
    end else if (state_q == ST_BURST) begin
      state_d = ST_IDLE;
      ptr_d   = inc_mod(owner_q);
    end
  end

  // Arbiter mode, back to idle on reset.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) state_q <= ST_IDLE;
    else state_q <= state_d;
  end

  register #(.W(PW)) u_ptr (
    .clk (clk), .rst_L (rst_L), .en (1'b1), .d (ptr_d), .q (ptr_q)
  );

  register #(.W(PW)) u_owner (
    .clk (clk), .rst_L (rst_L), .en (1'b1), .d (owner_d), .q (owner_q)
  );

  register #(.W(NREQ)) u_rvalid (
    .clk (clk), .rst_L (rst_L), .en (1'b1), .d (rv_d), .q (rv_q)
  );

  counter #(.W(CW)) u_burst_cnt (
    .clk      (clk),
    .rst_L    (rst_L),
    .load     (cnt_load),
    .load_val (CW'(1)),
    .inc      (cnt_inc),
    .q        (cnt_q)
  );

endmodule
